bip1_program_loader: RTL and testbench

- Writer side of the BIP1 program memory: receives a byte stream from the UART receiver and writes 16-bit instructions sequentially into program memory.
- Holds the CPU in reset while loading and releases it when the load completes.
- Sits between the UART RX block and the program-memory write port inside the BIP1 top level.

---
 rtl/bip1_pkg.sv | 31 +++
 rtl/bip1_loader_timeout.sv | 54 +++++
 rtl/bip1_program_loader.sv | 198 +++++++++++++++++++
 tb/tb_bip1_program_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip1_pkg.sv
// -----------------------------------------------------------------------------
// bip1_pkg
// Shared BIP1 definitions: program-loader state encoding, loader framing
// constants (sync byte, terminating word, inter-byte timeout) and the HLT
// opcode that the CPU decoder also uses.
// -----------------------------------------------------------------------------
package bip1_pkg;

  // Program-loader states.
  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_WAIT_LO,
    LDR_WAIT_HI,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_e;

  // BIP1 instructions carry a 5-bit opcode in the top bits; HLT is all zeros.
  localparam logic [4:0] OPCODE_HLT = 5'b00000;

  // Byte that opens a load session.
  localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

  // A load ends after writing "HLT 0", so the CPU stops cleanly at the end of
  // the program it was given.
  localparam logic [15:0] LDR_END_WORD = {OPCODE_HLT, 11'd0};

  // Idle clock cycles tolerated between two bytes of one session.
  localparam int unsigned LDR_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/bip1_loader_timeout.sv
// -----------------------------------------------------------------------------
// bip1_loader_timeout
// Inter-byte watchdog for the program loader: a down-counter that is reloaded
// to LIMIT-1 on every received byte, cleared while no session is running, and
// counts down (saturating at zero) while a session waits for data.
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset (counter -> 0)
//   i_load     reload to LIMIT-1 (highest priority)
//   i_clear    force the counter to 0
//   i_en       decrement by one, stopping at 0
//   o_expired  counter is 0; only meaningful while the loader is waiting
// -----------------------------------------------------------------------------
module bip1_loader_timeout #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int NB_CNT = $clog2(LIMIT + 1);

  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = NB_CNT'(LIMIT - 1);
    end else if (i_clear) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reloaded to LIMIT-1 by a byte, this reaches 0 exactly LIMIT-1 idle cycles
  // later, so the loader gives up on the LIMIT-th edge without a byte.
  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/bip1_program_loader.sv
// -----------------------------------------------------------------------------
// bip1_program_loader
// Writer side of the BIP1 program memory. A session opens with SYNC_BYTE and
// then carries 16-bit instructions as low byte / high byte pairs; each word is
// written to consecutive addresses starting at 0. The session completes after
// END_WORD has been written, and aborts on an inter-byte timeout or when the
// last address is written without END_WORD. The CPU is held in reset unless
// the most recent session completed normally.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_rx_data        byte from UART RX, valid while i_rx_done=1
//   i_rx_done        one-cycle strobe per received byte
//   o_wr_en          one-cycle program-memory write strobe
//   o_wr_addr        write address
//   o_wr_data        write data
//   o_cpu_rst        CPU reset request (active-high)
//   o_busy           session in progress
//   o_done           last session completed normally
//   o_error          last session aborted
//   o_word_count     words written in the current or last session
// -----------------------------------------------------------------------------
module bip1_program_loader
  import bip1_pkg::*;
#(
  parameter int unsigned           NB_INSTRUC        = 16,
  parameter int unsigned           NB_ADDR           = 11,
  parameter int unsigned           NB_BYTE           = 8,
  parameter int unsigned           RAM_DEPTH_PROGRAM = 2048,
  parameter logic [NB_BYTE-1:0]    SYNC_BYTE         = LDR_SYNC_BYTE,
  parameter logic [NB_INSTRUC-1:0] END_WORD          = LDR_END_WORD,
  parameter int unsigned           TIMEOUT_CYCLES    = LDR_TIMEOUT_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_wr_en,
  output logic [NB_ADDR-1:0]    o_wr_addr,
  output logic [NB_INSTRUC-1:0] o_wr_data,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [NB_ADDR:0]      o_word_count
);

  ldr_state_e            state_q,   state_d;
  logic [NB_BYTE-1:0]    lo_q,      lo_d;
  logic [NB_ADDR-1:0]    addr_q,    addr_d;
  logic                  wr_en_q,   wr_en_d;
  logic [NB_ADDR-1:0]    wr_addr_q, wr_addr_d;
  logic [NB_INSTRUC-1:0] wr_data_q, wr_data_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  error_q,   error_d;
  logic [NB_ADDR:0]      count_q,   count_d;

  logic                  in_wait;
  logic                  tmo_expired;
  logic                  timeout_hit;
  logic                  sync_seen;
  logic                  last_addr;
  logic [NB_INSTRUC-1:0] word;

  assign in_wait   = (state_q == LDR_WAIT_LO) || (state_q == LDR_WAIT_HI);
  // A byte on the expiry cycle wins over the timeout.
  assign timeout_hit = in_wait && tmo_expired && !i_rx_done;
  assign sync_seen = i_rx_done && (i_rx_data == SYNC_BYTE);
  assign last_addr = (addr_q == NB_ADDR'(RAM_DEPTH_PROGRAM - 1));
  assign word      = {i_rx_data, lo_q};

  bip1_loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (i_rx_done),
    .i_clear   (!in_wait),
    .i_en      (in_wait),
    .o_expired (tmo_expired)
  );

  always_comb begin
    // NOTE: every variable assigned here gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d   = state_q;
    lo_d      = lo_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    count_d   = count_q;

    unique case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERROR: begin
        // Status flags follow the terminal state one cycle after entry, so
        // o_done / o_cpu_rst release appear the cycle after the final write.
        if (state_q == LDR_DONE) begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else if (state_q == LDR_ERROR) begin
          busy_d    = 1'b0;
          error_d   = 1'b1;
          cpu_rst_d = 1'b1;
        end
        if (sync_seen) begin
          state_d   = LDR_WAIT_LO;
          busy_d    = 1'b1;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          count_d   = '0;
          addr_d    = '0;
        end
      end

      LDR_WAIT_LO: begin
        // Inside a session every byte is data, including SYNC_BYTE.
        if (i_rx_done) begin
          lo_d    = i_rx_data;
          state_d = LDR_WAIT_HI;
        end else if (timeout_hit) begin
          state_d = LDR_ERROR;
        end
      end

      LDR_WAIT_HI: begin
        if (i_rx_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = word;
          addr_d    = addr_q + 1'b1;
          count_d   = count_q + 1'b1;
          if (word == END_WORD) begin
            state_d = LDR_DONE;
          end else if (last_addr) begin
            // Never wrap onto address 0: a full memory without END_WORD aborts.
            state_d = LDR_ERROR;
          end else begin
            state_d = LDR_WAIT_LO;
          end
        end else if (timeout_hit) begin
          // The half-received word is simply dropped.
          state_d = LDR_ERROR;
        end
      end

      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= LDR_IDLE;
      lo_q      <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      lo_q      <= lo_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_bip1_program_loader.sv
// -----------------------------------------------------------------------------
// tb_bip1_program_loader
// Drives byte streams into the loader and compares the write port and status
// flags against a byte-stream reference model. Expected writes are queued when
// the completing byte is sent; a monitor pops one per observed write strobe.
// -----------------------------------------------------------------------------
module tb_bip1_program_loader;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_rst, busy, done, error;
  logic [11:0] word_count;

  bip1_program_loader #(
    .RAM_DEPTH_PROGRAM (DEPTH),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int addr;
    int data;
    int count;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: a session is either open or not; words are pairs of bytes.
  bit         m_active, m_have_lo, m_done, m_err, m_cpurst;
  logic [7:0] m_lo;
  int         m_addr, m_count;
  int         idle_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_have_lo = 0; m_done = 0; m_err = 0; m_cpurst = 1;
    m_lo = '0; m_addr = 0; m_count = 0;
  endfunction

  function automatic void model_timeout();
    if (m_active) begin
      m_active = 0; m_have_lo = 0; m_err = 1;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [15:0] w;
    if (!m_active) begin
      if (b == 8'hA5) begin
        m_active = 1; m_have_lo = 0; m_done = 0; m_err = 0; m_cpurst = 1;
        m_addr = 0; m_count = 0;
      end
    end else if (!m_have_lo) begin
      m_lo = b; m_have_lo = 1;
    end else begin
      w = {b, m_lo};
      exp_q.push_back('{m_addr, int'(w), m_count + 1});
      m_addr++; m_count++; m_have_lo = 0;
      if (w == 16'h0000) begin
        m_active = 0; m_done = 1; m_cpurst = 0;
      end else if (m_addr == DEPTH) begin
        m_active = 0; m_err = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    idle_run++;
  endtask

  // idle = clock edges without a byte before this one (0 = back-to-back).
  task automatic send(input logic [7:0] b, input int idle);
    repeat (idle) tick();
    if (idle_run + 1 > TMO) model_timeout();
    model_byte(b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done  = 1'b0;
    idle_run = 0;
  endtask

  task automatic check_status(input string tag);
    if (idle_run > TMO) model_timeout();
    check({tag, "_busy"},  busy,       m_active);
    check({tag, "_done"},  done,       m_done);
    check({tag, "_error"}, error,      m_err);
    check({tag, "_cpu"},   cpu_rst,    m_cpurst);
    check({tag, "_count"}, word_count, m_count);
  endtask

  task automatic settle(input string tag, input int n);
    repeat (n) tick();
    check_status(tag);
  endtask

  // Monitor: one expected write is consumed per observed strobe.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && wr_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr",  wr_addr,    e.addr);
          check("wr_data",  wr_data,    e.data);
          check("wr_count", word_count, e.count);
          check("wr_busy",  busy,       1);
          check("wr_done",  done,       0);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check("rst_wr_en",   wr_en,      0);
    check("rst_wr_addr", wr_addr,    0);
    check("rst_wr_data", wr_data,    0);
    check("rst_cpu",     cpu_rst,    1);
    check("rst_busy",    busy,       0);
    check("rst_done",    done,       0);
    check("rst_error",   error,      0);
    check("rst_count",   word_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    idle_run = 0;

    // Basic load: one instruction then HLT.
    send(8'hA5, 0); send(8'h02, 0); send(8'h18, 0); send(8'h00, 1); send(8'h00, 0);
    settle("t1", 2);

    // Junk before sync is ignored, then a normal load.
    send(8'h11, 1); send(8'h22, 0);
    settle("t2_junk", 2);
    send(8'hA5, 0); send(8'h34, 0); send(8'h12, 0); send(8'h00, 0); send(8'h00, 0);
    settle("t2", 2);

    // Timeout with a half word pending, then recovery.
    send(8'hA5, 0); send(8'h01, 0);
    settle("t3_busy", 3);
    repeat (TMO + 3) tick();
    check_status("t3_tmo");
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    settle("t3", 2);

    // Timeout boundary: a byte on the expiry cycle wins; one cycle later loses.
    send(8'hA5, 0); send(8'h01, 0); send(8'h02, TMO - 1); send(8'h00, 0); send(8'h00, 0);
    settle("t3_edge_ok", 2);
    send(8'hA5, 0); send(8'h01, 0); send(8'h02, TMO);
    settle("t3_edge_tmo", 2);

    // Memory full without END_WORD, all bytes back-to-back.
    send(8'hA5, 0);
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(i + 1), 0);
      send(8'h80, 0);
    end
    settle("t4_full", 2);

    // SYNC value inside a session is data.
    send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    settle("t5_sync_data", 2);

    // Asynchronous reset mid-word.
    send(8'hA5, 0); send(8'h34, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_wr_en", wr_en,      0);
    check("arst_cpu",   cpu_rst,    1);
    check("arst_busy",  busy,       0);
    check("arst_done",  done,       0);
    check("arst_error", error,      0);
    check("arst_count", word_count, 0);
    check("arst_addr",  wr_addr,    0);
    check("arst_data",  wr_data,    0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    idle_run = 0;
    // After reset a leftover high byte must not complete a word.
    send(8'h12, 0);
    settle("arst_after", 2);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      int nwords;
      int njunk;
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) send(8'($urandom), $urandom_range(0, 2));
      send(8'hA5, $urandom_range(0, 2));
      nwords = $urandom_range(1, 10);
      for (int i = 0; i < nwords; i++) begin
        logic [7:0] lo, hi;
        int gap;
        lo = 8'($urandom);
        hi = 8'($urandom);
        if ((i == nwords - 1) && ($urandom_range(0, 1) == 1)) begin
          lo = 8'h00;
          hi = 8'h00;
        end
        gap = $urandom_range(0, 3);
        if ($urandom_range(0, 19) == 0) gap = TMO - 1 + $urandom_range(0, 1);
        send(lo, gap);
        send(hi, $urandom_range(0, 3));
      end
      settle("rnd", 2);
    end

    // Every queued write must have been seen.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
